// File: rtl/mp_cond_sub.sv
// mp_cond_sub: multi-cycle conditional subtraction.
// Reduces x by m once (x - m when x >= m, otherwise x) by rippling a
// LIMB-bit subtractor over the operands, least significant limb first.
// The borrow out of the top limb decides whether the difference or the
// original x becomes the result.
module mp_cond_sub #(
    parameter int WIDTH = 1028,
    parameter int LIMB  = 257
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-2:0] in_m,
    output logic             busy,
    output logic             done,
    output logic             ge,
    output logic [WIDTH-2:0] result
);

    localparam int NLIMB = WIDTH / LIMB;
    localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [WIDTH-1:0] diff_next;
    logic             borrow_reg;
    logic             borrow_next;
    logic [CW-1:0]    k_reg;
    logic             last_limb;

    logic [LIMB-1:0]  x_limbs [NLIMB];
    logic [LIMB-1:0]  m_limbs [NLIMB];
    logic [LIMB-1:0]  x_limb;
    logic [LIMB-1:0]  m_limb;
    logic [LIMB-1:0]  d_limb;

    // Split the captured operands into limbs and splice the freshly computed
    // difference limb into the running difference at position k.
    generate
        for (genvar gi = 0; gi < NLIMB; gi++) begin : g_limb
            assign x_limbs[gi] = x_reg[gi*LIMB +: LIMB];
            assign m_limbs[gi] = m_reg[gi*LIMB +: LIMB];
            assign diff_next[gi*LIMB +: LIMB] =
                (k_reg == CW'(gi)) ? d_limb : diff_reg[gi*LIMB +: LIMB];
        end
    endgenerate

    assign x_limb    = x_limbs[k_reg];
    assign m_limb    = m_limbs[k_reg];
    assign last_limb = (k_reg == CW'(NLIMB - 1));

    // One limb of x - m - borrow; the extra top bit is the borrow out.
    always_comb begin
        {borrow_next, d_limb} = {1'b0, x_limb} - {1'b0, m_limb}
                              - {{LIMB{1'b0}}, borrow_reg};
    end

    // Sequencer: capture in IDLE, one limb per SUB cycle, publish in DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            x_reg      <= '0;
            m_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            k_reg      <= '0;
            ge         <= 1'b0;
            result     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg      <= in_x;
                        m_reg      <= {1'b0, in_m};
                        borrow_reg <= 1'b0;
                        k_reg      <= '0;
                        state_reg  <= SUB;
                    end
                end
                SUB: begin
                    diff_reg   <= diff_next;
                    borrow_reg <= borrow_next;
                    k_reg      <= k_reg + 1'b1;
                    if (last_limb) begin
                        // Final borrow set means x < m: keep x untouched.
                        state_reg <= DONE;
                        ge        <= ~borrow_next;
                        result    <= borrow_next ? x_reg[WIDTH-2:0]
                                                 : diff_next[WIDTH-2:0];
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_mp_cond_sub.sv
// Testbench for mp_cond_sub: directed corner cases, randomized operands
// against a plain-arithmetic reference, back-to-back and reset abort.
`timescale 1ns/1ps
module tb_mp_cond_sub;

    localparam int W = 1028;
    localparam int L = 257;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [W-1:0] in_x;
    logic [W-2:0] in_m;
    logic         busy;
    logic         done;
    logic         ge;
    logic [W-2:0] result;

    int errors = 0;
    int checks = 0;

    mp_cond_sub #(.WIDTH(W), .LIMB(L)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_x   (in_x),
        .in_m   (in_m),
        .busy   (busy),
        .done   (done),
        .ge     (ge),
        .result (result)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W / 32 + 1; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    // Reference: single conditional subtraction, truncated to W-1 bits.
    function automatic void ref_op(input logic [W-1:0] x, input logic [W-2:0] m,
                                   output logic g, output logic [W-2:0] r);
        logic [W-1:0] mx;
        logic [W-1:0] d;
        mx = {1'b0, m};
        g  = (x >= mx);
        d  = x - mx;
        r  = g ? d[W-2:0] : x[W-2:0];
    endfunction

    // Drives one operation from IDLE (start in cycle 0) and reports what was
    // seen: done latency in cycles (-1 on timeout), outputs at done, whether
    // busy stayed high and ge/result stayed put until done. Operand inputs are
    // scrambled right after capture; optional extra starts at cycles 2 and 3.
    task automatic run_op(input logic [W-1:0] x, input logic [W-2:0] m,
                          input bit extra_starts,
                          output int lat, output logic g, output logic [W-2:0] r,
                          output bit busy_ok, output bit stable_ok);
        logic         g0;
        logic [W-2:0] r0;
        logic [W-1:0] junk;
        g0 = ge;
        r0 = result;
        in_x = x;
        in_m = m;
        start = 1'b1;
        tick();
        junk = rand_wide();
        in_x = junk;
        junk = rand_wide();
        in_m = junk[W-2:0];
        lat = -1;
        g = 1'b0;
        r = '0;
        busy_ok = 1'b1;
        stable_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            start = (extra_starts && (c == 2 || c == 3));
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                g = ge;
                r = result;
                break;
            end
            if (ge !== g0 || result !== r0) stable_ok = 1'b0;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b1;
        in_x = 1028'd5;
        in_m = 1027'd3;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ge !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b ge=%b result_zero=%b, required all 0",
                     busy, done, ge, result == '0);
        end
        start = 1'b0;
        resetn = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b, required 0", busy);
        end
        $display("test_reset: done");
    endtask

    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-2:0] m,
                            input logic eg, input logic [W-2:0] er);
        int lat; logic g; logic [W-2:0] r; bit bok; bit sok;
        run_op(x, m, 1'b0, lat, g, r, bok, sok);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required 5", name, lat);
        end
        checks++;
        if (g !== eg || r !== er) begin
            errors++;
            $display("FAIL %s_value: ge=%b result=%h, required ge=%b result=%h",
                     name, g, r[63:0], eg, er[63:0]);
        end
        checks++;
        if (!bok || !sok) begin
            errors++;
            $display("FAIL %s_busy_stable: busy_ok=%b stable_ok=%b, required 1 1", name, bok, sok);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ge !== eg || result !== er) begin
            errors++;
            $display("FAIL %s_after: busy=%b done=%b ge=%b, required 0 0 %b, result held",
                     name, busy, done, ge, eg);
        end
        $display("directed %s: ge=%b lat=%0d", name, g, lat);
    endtask

    task automatic test_directed();
        logic [W-1:0] v;
        logic [W-1:0] e;
        directed("x5_m3", 1028'd5, 1027'd3, 1'b1, 1027'd2);
        directed("x3_m5", 1028'd3, 1027'd5, 1'b0, 1027'd3);
        v = '0;
        v[1026] = 1'b1;
        v = v + 1028'd7;
        directed("x_eq_m", v, v[W-2:0], 1'b1, '0);
        v = '0;
        v[771] = 1'b1;
        e = v - 1028'd1;
        directed("borrow_ripple", v, 1027'd1, 1'b1, e[W-2:0]);
    endtask

    task automatic test_random();
        logic [W-1:0] x; logic [W-2:0] m; logic [W-1:0] t;
        logic eg; logic [W-2:0] er;
        int lat; logic g; logic [W-2:0] r; bit bok; bit sok;
        for (int i = 0; i < 24; i++) begin
            t = rand_wide();
            m = t[W-2:0];
            m[W-2] = 1'b1;
            t = rand_wide();
            case (i % 4)
                0: x = {1'b0, m};
                1: x = {1'b0, m} + (t >> 2);
                2: x = {1'b0, m} - ((t >> 2) + 1'b1);
                default: x = t;
            endcase
            ref_op(x, m, eg, er);
            run_op(x, m, 1'b0, lat, g, r, bok, sok);
            checks++;
            if (lat !== 5 || g !== eg || r !== er || !bok || !sok) begin
                errors++;
                $display("FAIL random_%0d: lat=%0d ge=%b res=%h busy_ok=%b stable_ok=%b, required lat=5 ge=%b res=%h",
                         i, lat, g, r[63:0], bok, sok, eg, er[63:0]);
            end
            $display("random %0d: mode=%0d ge=%b", i, i % 4, g);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic g; logic [W-2:0] r; bit bok; bit sok;
        logic eg; logic [W-2:0] er;
        run_op(1028'd100, 1027'd58, 1'b1, lat, g, r, bok, sok);
        checks++;
        if (lat !== 5 || g !== 1'b1 || r !== 1027'd42) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d ge=%b res=%0d, required 5 1 42", lat, g, r[31:0]);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_single_done: done=%b busy=%b, required 0 0", done, busy);
        end
        // Cycle 6: new op; its done lands at cycle 11.
        ref_op(1028'd7, 1027'd9, eg, er);
        run_op(1028'd7, 1027'd9, 1'b0, lat, g, r, bok, sok);
        checks++;
        if (lat !== 5 || g !== eg || r !== er) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d ge=%b res=%0d, required 5 %b %0d",
                     lat, g, r[31:0], eg, er[31:0]);
        end
        $display("back_to_back: second ge=%b", g);
        tick();
    endtask

    task automatic test_reset_abort();
        int lat; logic g; logic [W-2:0] r; bit bok; bit sok;
        bit saw_done;
        in_x = 1028'd20;
        in_m = 1027'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ge !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b ge=%b result=%0d, required all 0",
                     busy, done, ge, result[31:0]);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: saw done=1, required none");
        end
        run_op(1028'd10, 1027'd4, 1'b0, lat, g, r, bok, sok);
        checks++;
        if (lat !== 5 || g !== 1'b1 || r !== 1027'd6) begin
            errors++;
            $display("FAIL abort_restart: lat=%0d ge=%b res=%0d, required 5 1 6", lat, g, r[31:0]);
        end
        $display("reset_abort: restart ge=%b res=%0d", g, r[31:0]);
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        in_x = '0;
        in_m = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mp_cond_sub.md
MP_COND_SUB -- requirements
Module: mp_cond_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 1028, meaning bit width of the input value x (the adder result width).
REQ-002 SHALL have parameter LIMB, default 257, meaning bits subtracted per cycle; WIDTH SHALL be an exact multiple of LIMB (NLIMB = WIDTH/LIMB = 4).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle request; sampled only in IDLE.
REQ-006 in_x  input  WIDTH  value to reduce (adder output).
REQ-007 in_m  input  WIDTH-1  modulus.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 ge  output  1  1 when x >= m for the completed operation.
REQ-011 result  output  WIDTH-1  x-m if x >= m, else x[WIDTH-2:0].

Function
REQ-012 SHALL implement FSM states IDLE, SUB, DONE.
REQ-013 IDLE with start=1: SHALL capture in_x and in_m (zero-extended to WIDTH) into internal registers, clear borrow, clear limb counter, go to SUB.
REQ-014 IDLE with start=0: SHALL stay in IDLE; done=0, busy=0.
REQ-015 SUB: each cycle SHALL compute limb k of x-m as x[k]-m[k]-borrow over LIMB bits, store the difference limb, update borrow, and increment k.
REQ-016 Limbs SHALL be processed LSB first, k = 0..NLIMB-1; exactly NLIMB SUB cycles.
REQ-017 After limb NLIMB-1: SHALL go to DONE; ge = NOT final borrow.
REQ-018 DONE: SHALL drive done=1 for exactly one cycle; result = difference[WIDTH-2:0] if ge else captured x[WIDTH-2:0]; then go to IDLE.
REQ-019 Latency: with start high in cycle 0, done SHALL be high in cycle NLIMB+1 (cycle 5 at defaults).
REQ-020 busy SHALL be 1 in SUB and DONE, 0 in IDLE.
REQ-021 result and ge SHALL hold their value from DONE until the next DONE; they SHALL NOT change during SUB.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-023 start in the cycle after done (state IDLE) SHALL be accepted; this gives back-to-back throughput of one operation per NLIMB+2 cycles.
REQ-024 in_x/in_m changes after capture SHALL NOT affect the running operation.
REQ-025 Precondition, owned by the caller: in_x < 2*in_m; the module SHALL NOT check it, and result is the truncated difference regardless.
REQ-026 x = m SHALL yield ge=1, result=0.

Reset
REQ-027 resetn=0 at a rising edge SHALL force state IDLE, busy=0, done=0, ge=0, result=0, borrow=0, limb counter=0.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse; the first start after resetn returns high SHALL run normally.
REQ-029 start SHALL be ignored in any cycle where resetn=0.

Verification
REQ-030 x=5, m=3, start pulse -> done at cycle 5, ge=1, result=2, busy high for cycles 1-5.
REQ-031 x=3, m=5 -> done at cycle 5, ge=0, result=3.
REQ-032 x=m=2^1026+7 -> ge=1, result=0.
REQ-033 x=2^771, m=1 -> ge=1, result=2^771-1 (borrow ripples through limbs 0-2).
REQ-034 Start pulses at cycles 2 and 3 of a running op -> ignored, single done at cycle 5; a start at cycle 6 -> second done at cycle 11.
REQ-035 resetn=0 at cycle 3 of an op -> no done, all outputs 0; new op x=10, m=4 after reset -> result=6, ge=1.
